// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between fifo_burst_reader, the ring_buffer read port and the
// downstream burst consumer.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  flush;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;

  modport master (
    input  fifo_head, fifo_empty, flush, out_ready,
    output fifo_pop, out_data, out_valid, out_last, busy
  );

  modport slave (
    output fifo_head, fifo_empty, flush, out_ready,
    input  fifo_pop, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains ring_buffer entries into a valid/ready stream grouped into bursts of up
// to BURST_LEN beats; a burst closes early on FIFO-empty timeout or flush.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_reader_if.master bus
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit ONE_BEAT = (BURST_LEN == 1);

  typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic [BW-1:0]         beat_idx;
  logic [BW-1:0]         nxt_idx;
  logic [TW-1:0]         timer;
  logic                  pop;

  assign nxt_idx = beat_idx + BW'(1);

  // Pop only where a load happens: IDLE start, or SEND handshake with data waiting.
  always_comb begin
    pop = 1'b0;
    if (!rst && !bus.fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SEND:    pop = bus.out_ready;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      beat_idx <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.fifo_empty) begin
            data_q   <= bus.fifo_head;
            beat_idx <= '0;
            timer    <= '0;
            if (ONE_BEAT) begin
              state   <= SEND;
              valid_q <= 1'b1;
              last_q  <= 1'b1;
            end else begin
              state   <= HOLD;
            end
          end
        end

        // Beat is parked until we know whether another entry follows it.
        HOLD: begin
          if (bus.flush) begin
            state   <= SEND;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            timer   <= '0;
          end else if (!bus.fifo_empty) begin
            state   <= SEND;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            timer   <= '0;
          end else if (TIMEOUT != 0 && timer == TO_LAST) begin
            state   <= SEND;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            timer   <= '0;
          end else begin
            timer   <= timer + TW'(1);
          end
        end

        SEND: begin
          if (bus.out_ready) begin
            if (!last_q) begin
              data_q   <= bus.fifo_head;
              beat_idx <= nxt_idx;
              if (nxt_idx == LAST_IDX) begin
                last_q <= 1'b1;
              end else begin
                state   <= HOLD;
                valid_q <= 1'b0;
                timer   <= '0;
              end
            end else begin
              beat_idx <= '0;
              if (!bus.fifo_empty) begin
                data_q <= bus.fifo_head;
                timer  <= '0;
                if (!ONE_BEAT) begin
                  state   <= HOLD;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                end
              end else begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural FIFO model, beat/pop logger,
// hand-computed expectations.
module tb_fifo_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.DATA_WIDTH(8)) fif();

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif.master)
  );

  // FIFO model: pushes from the stimulus thread, pops on the DUT strobe
  logic [7:0] fmem [0:63];
  int wr = 0;
  int rd = 0;
  assign fif.fifo_empty = (rd == wr);
  assign fif.fifo_head  = fmem[rd[5:0]];
  always @(posedge clk) if (fif.fifo_pop) rd <= rd + 1;

  // beat / pop logger, sampled mid-cycle
  logic [8:0] blog [0:63];
  int nb = 0;
  int np = 0;
  always @(negedge clk) begin
    if (fif.out_valid && fif.out_ready) begin
      blog[nb[5:0]] <= {fif.out_last, fif.out_data};
      nb <= nb + 1;
    end
    if (fif.fifo_pop) np <= np + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr[5:0]] = d;
    wr++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int s, p, done, early, stable;
    logic [8:0] e;
    fif.out_ready = 1'b0;
    fif.flush     = 1'b0;
    tick(); tick();
    chk("rst_valid", fif.out_valid, 0);
    chk("rst_last",  fif.out_last,  0);
    chk("rst_data",  fif.out_data,  0);
    chk("rst_busy",  fif.busy,      0);
    chk("rst_pop",   fif.fifo_pop,  0);
    rst = 1'b0;
    tick();

    // two full bursts
    s = nb; p = np; done = 0;
    fif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (nb - s >= 8 && !fif.busy) done = 1;
    end
    chk("t1_done", done, 1);
    for (int i = 0; i < 8; i++) begin
      e = {((i % 4) == 3), 8'h10 + 8'(i)};
      chk("t1_beat", blog[s + i], e);
    end
    chk("t1_pops", np - p, 8);
    chk("t1_busy", fif.busy, 0);

    // timeout close
    fif.out_ready = 1'b0;
    push(8'hA5);
    tick();
    chk("t2_hold_busy", fif.busy, 1);
    chk("t2_hold_valid", fif.out_valid, 0);
    early = 0;
    repeat (15) begin tick(); if (fif.out_valid) early = 1; end
    chk("t2_early", early, 0);
    tick();
    chk("t2_valid", fif.out_valid, 1);
    chk("t2_last",  fif.out_last,  1);
    chk("t2_data",  fif.out_data,  8'hA5);
    fif.out_ready = 1'b1;
    tick();
    chk("t2_idle", fif.busy, 0);

    // backpressure, then flush of held beat 1
    fif.out_ready = 1'b0;
    push(8'h20); push(8'h21);
    tick(); tick();
    stable = 1;
    repeat (5) begin
      if (!(fif.out_valid && fif.out_data == 8'h20 && !fif.out_last && !fif.fifo_pop)) stable = 0;
      tick();
    end
    chk("t3_stable", stable, 1);
    chk("t3_data", fif.out_data, 8'h20);
    fif.out_ready = 1'b1;
    #1;
    chk("t3_pop", fif.fifo_pop, 1);
    s = nb;
    tick();
    chk("t3_xfer", blog[s], {1'b0, 8'h20});
    chk("t3_hold", fif.out_valid, 0);
    tick(); tick(); tick();
    fif.flush = 1'b1;
    tick();
    fif.flush = 1'b0;
    chk("t4_valid", fif.out_valid, 1);
    chk("t4_last",  fif.out_last,  1);
    chk("t4_data",  fif.out_data,  8'h21);
    tick();
    chk("t4_idle", fif.busy, 0);

    // late arrival at timer == TIMEOUT-2
    push(8'h40);
    tick();
    repeat (14) tick();
    push(8'h41);
    tick();
    chk("t5_valid", fif.out_valid, 1);
    chk("t5_last",  fif.out_last,  0);
    chk("t5_data",  fif.out_data,  8'h40);
    chk("t5_pop",   fif.fifo_pop,  1);
    tick();
    early = 0;
    repeat (15) begin tick(); if (fif.out_valid) early = 1; end
    chk("t5_early", early, 0);
    tick();
    chk("t5_last2", {fif.out_valid, fif.out_last, fif.out_data}, {2'b11, 8'h41});
    tick();
    chk("t5_idle", fif.busy, 0);

    // reset mid-burst; 0x53 stays in the FIFO and joins the refill
    s = nb;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    repeat (5) tick();
    chk("t6_two", nb - s, 2);
    rst = 1'b1;
    tick();
    chk("t6_rvalid", fif.out_valid, 0);
    chk("t6_rlast",  fif.out_last,  0);
    chk("t6_rdata",  fif.out_data,  0);
    chk("t6_rbusy",  fif.busy,      0);
    chk("t6_rpop",   fif.fifo_pop,  0);
    rst = 1'b0;
    s = nb; done = 0;
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      if (nb - s >= 4 && !fif.busy) done = 1;
    end
    chk("t6_done", done, 1);
    chk("t6_b0", blog[s],     {1'b0, 8'h53});
    chk("t6_b1", blog[s + 1], {1'b0, 8'h60});
    chk("t6_b2", blog[s + 2], {1'b0, 8'h61});
    chk("t6_b3", blog[s + 3], {1'b1, 8'h62});
    chk("t6_cnt", nb - s, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
